decryptor_unit: RTL and testbench
=================================

// Module: decryptor_unit
// PURPOSE
//  Inverse of the encrypt datapath (Num -> rotate right by 2 -> x Key -> 16x8 store).
//  Holds a 16-entry x 8-bit cipher store. On start, it reads one entry, divides it by Key
//  with a sequential restoring divider, and rotates the 4-bit quotient left by 2 to recover Num.
//  Sits beside the encryptor as the read/decode end of the same stored-cipher interface.
// PARAMETERS
//  DW     8  cipher word width (product width)
//  NW     4  plaintext / key width
//  DEPTH  16 store entries; address width = log2(DEPTH) = 4
//  ROT    2  rotate-left amount applied to the quotient
// PORTS
//  clock      in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high
//  load_we    in   1   write enable into the cipher store
//  load_addr  in   4   store write index (0..15)
//  load_data  in   8   cipher word to store
//  start      in   1   begin a decrypt; sampled only in IDLE
//  rd_addr    in   4   entry to decrypt; captured with start
//  key        in   4   divisor; captured with start
//  busy       out  1   high from the cycle after start until done
//  done       out  1   one-cycle pulse; num_out/error valid that cycle and held until next start
//  num_out    out  4   recovered plaintext
//  error      out  1   key==0, nonzero remainder, or quotient > 15
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, num_out=0, error=0; all 16 store entries cleared to 8'h00.
//  Store: a write at a clock edge with load_we=1 sets mem[load_addr]. Writes are accepted in any state.
//  FSM states:
//   IDLE   -> FETCH on start=1; latch rd_addr and key.
//   FETCH  dividend <= mem[addr]. key==0 -> FIN with error=1. Otherwise -> DIV with count=8.
//   DIV    one restoring step per cycle over 8 dividend bits with a 5-bit partial remainder.
//          count decrements each step; at count==1 -> ROT.
//   ROT    error = (rem!=0) | (quot[7:4]!=0); num_out = {quot[1:0], quot[3:2]}; -> FIN.
//   FIN    done=1 for one cycle, busy=0; -> IDLE.
//  Latency, start sampled at edge 0:
//   normal: done high in the cycle after edge 11 (FETCH 1 + DIV 8 + ROT 1 + FIN).
//   key==0: done high in the cycle after edge 2.
//  Boundaries:
//   start while busy: ignored, not queued.
//   load_we to the entry being decrypted during FETCH: the old value is used (read-before-write);
//   after FETCH a write has no effect on the running decrypt.
//   rd_addr/key changes after the start edge: no effect.
//   reset mid-operation: abort to IDLE and clear outputs and the store; no done pulse.
//   start in the FIN cycle: ignored (the FSM is not in IDLE).
//   num_out holds its last value until the next ROT/FIN. On error, num_out=4'h0.
// STRUCTURE
//  Package decryptor_pkg: state encoding (IDLE, FETCH, DIV, ROT, FIN), DW/NW/DEPTH/ROT constants,
//  divider iteration count (8).
//  Sub-module seq_divider_8by4: load/step interface, quot[7:0], rem[3:0], done flag.
//  Store array and FSM live in the top module.
// TESTING
//  1 load mem[8]=8'h10; start rd_addr=8 key=4'b1000 -> done at cycle 11, num_out=4'b1000, error=0.
//  2 mem[8]=8'h30 key=8 -> 4'b1001; mem[3]=8'h1E key=4'b1010 -> 4'b1100;
//    mem[F]=8'hC4 key=4'b1110 -> 4'b1011.
//  3 error paths: mem[2]=8'h11 key=8 -> error=1 (remainder); key=0 -> done at cycle 2, error=1;
//    mem[0]=8'hF0 key=1 -> error=1 (quotient > 15); num_out=0 in each case.
//  4 start pulsed again at cycle 5 of a run -> ignored, single done pulse. Write mem[8]=8'hFF at
//    cycle 4 -> the result still uses the old 8'h10.
//  5 reset asserted at cycle 6 of a run -> next cycle busy=0, done=0, num_out=0, mem[8]=0;
//    no done pulse follows.
//  6 back-to-back: start in the cycle after done -> accepted; second result is correct.

Source files
------------

// File: rtl/decryptor_pkg.sv
// Shared constants, state encoding and the quotient rotate helper for the decryptor.
package decryptor_pkg;

    localparam int unsigned DW        = 8;
    localparam int unsigned NW        = 4;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned ROT       = 2;
    localparam int unsigned DIV_STEPS = 8;
    localparam int unsigned CW        = $clog2(DIV_STEPS + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DIV   = 3'd2,
        ST_ROT   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // Undo the encryptor's rotate-right by rotating the quotient left.
    function automatic logic [NW-1:0] rotl(input logic [NW-1:0] x);
        rotl = NW'((x << ROT) | (x >> (NW - ROT)));
    endfunction

endpackage

// File: rtl/seq_divider_8by4.sv
// Restoring divider: 8-bit dividend by 4-bit divisor, one quotient bit per step.
module seq_divider_8by4
    import decryptor_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [NW-1:0] divisor,
    output logic [DW-1:0] quot,
    output logic [NW-1:0] rem,
    output logic          done
);

    logic [NW:0]   rem_sh;
    logic [NW:0]   rem_sub;
    logic          q_bit;
    logic [NW-1:0] rem_next;
    logic [CW-1:0] cnt;

    // Shift in the next dividend bit and trial-subtract the divisor.
    always_comb begin
        rem_sh   = {rem, quot[DW-1]};
        rem_sub  = rem_sh - {1'b0, divisor};
        q_bit    = (rem_sh >= {1'b0, divisor});
        rem_next = NW'(q_bit ? rem_sub : rem_sh);
    end

    // Quotient bits replace dividend bits in the same shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            quot <= '0;
            rem  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (load) begin
            quot <= dividend;
            rem  <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (step) begin
            quot <= {quot[DW-2:0], q_bit};
            rem  <= rem_next;
            cnt  <= cnt + CW'(1);
            done <= (cnt == CW'(DIV_STEPS - 1));
        end
    end

endmodule

// File: rtl/decryptor_unit.sv
// Cipher store plus decrypt sequencer: fetch, divide by key, rotate quotient left.
module decryptor_unit
    import decryptor_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    input  logic          start,
    input  logic [AW-1:0] rd_addr,
    input  logic [NW-1:0] key,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] num_out,
    output logic          error
);

    logic [DW-1:0] mem [DEPTH];

    state_t        state, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [NW-1:0] key_q, key_d;
    logic [CW-1:0] count, count_d;
    logic          busy_d, done_d, error_d;
    logic [NW-1:0] num_d;
    logic          div_load, div_step, div_done;
    logic [DW-1:0] div_quot;
    logic [NW-1:0] div_rem;
    logic          rot_err;

    // Cipher store; a write in the FETCH cycle lands after the read.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (load_we) begin
            mem[load_addr] <= load_data;
        end
    end

    seq_divider_8by4 u_div (
        .clock    (clock),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (mem[addr_q]),
        .divisor  (key_q),
        .quot     (div_quot),
        .rem      (div_rem),
        .done     (div_done)
    );

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            key_q   <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            num_out <= '0;
            error   <= 1'b0;
        end else begin
            state   <= state_d;
            addr_q  <= addr_d;
            key_q   <= key_d;
            count   <= count_d;
            busy    <= busy_d;
            done    <= done_d;
            num_out <= num_d;
            error   <= error_d;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d  = state;
        addr_d   = addr_q;
        key_d    = key_q;
        count_d  = count;
        busy_d   = busy;
        done_d   = 1'b0;
        num_d    = num_out;
        error_d  = error;
        div_load = 1'b0;
        div_step = 1'b0;
        rot_err  = (div_rem != '0) || (div_quot[DW-1:NW] != '0) || !div_done;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = rd_addr;
                    key_d   = key;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (key_q == '0) begin
                    error_d = 1'b1;
                    num_d   = '0;
                    state_d = ST_FIN;
                end else begin
                    div_load = 1'b1;
                    count_d  = CW'(DIV_STEPS);
                    state_d  = ST_DIV;
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                count_d  = count - CW'(1);
                if (count == CW'(1)) state_d = ST_ROT;
            end
            ST_ROT: begin
                error_d = rot_err;
                num_d   = rot_err ? '0 : rotl(div_quot[NW-1:0]);
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_decryptor_unit.sv
// Randomised and directed bench for decryptor_unit against an arithmetic reference model.
module tb_decryptor_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_we;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       start;
    logic [3:0] rd_addr;
    logic [3:0] key;
    logic       busy;
    logic       done;
    logic [3:0] num_out;
    logic       error;

    int checks = 0;
    int passed = 0;
    logic [7:0] mem_m [16];

    decryptor_unit dut (
        .clock     (clock),
        .reset     (reset),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .start     (start),
        .rd_addr   (rd_addr),
        .key       (key),
        .busy      (busy),
        .done      (done),
        .num_out   (num_out),
        .error     (error)
    );

    always #5 clock = ~clock;

    // Reference: {error, num}. Encryption was num -> ror2 -> *key, so invert arithmetically.
    function automatic logic [4:0] model(input logic [7:0] d, input logic [3:0] k);
        int q, r, n;
        if (k == 0) return 5'b1_0000;
        q = int'(d) / int'(k);
        r = int'(d) % int'(k);
        if (r != 0 || q > 15) return 5'b1_0000;
        n = ((q * 4) % 16) + (q / 4);
        return {1'b0, 4'(n)};
    endfunction

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        load_we = 1'b1; load_addr = a; load_data = d;
        @(posedge clock); #1;
        load_we = 1'b0;
        mem_m[a] = d;
    endtask

    // Start sampled at the next edge (edge 0); inputs scrambled afterwards.
    task automatic launch(input logic [3:0] a, input logic [3:0] k);
        rd_addr = a; key = k; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        rd_addr = 4'($urandom); key = 4'($urandom);
    endtask

    // Returns the edge number after which done was seen, or -1 on timeout.
    task automatic wait_done(output int lat);
        int c;
        c = 0; lat = -1;
        while (c < 40) begin
            @(posedge clock); #1;
            c++;
            if (done) begin lat = c; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; rd_addr = '0; key = '0;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b exp 0", done); else passed++;
        checks++; if (num_out !== 4'h0) $display("FAIL reset_num got %0h exp 0", num_out); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL reset_error got %0b exp 0", error); else passed++;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_vectors;
        logic [3:0] va [7] = '{4'h8, 4'h8, 4'h3, 4'hF, 4'h2, 4'h5, 4'h0};
        logic [7:0] vd [7] = '{8'h10, 8'h30, 8'h1E, 8'hC4, 8'h11, 8'h42, 8'hF0};
        logic [3:0] vk [7] = '{4'h8, 4'h8, 4'hA, 4'hE, 4'h8, 4'h0, 4'h1};
        int lat, exp_lat;
        logic [4:0] exp;
        for (int i = 0; i < 7; i++) begin
            write_mem(va[i], vd[i]);
            exp = model(vd[i], vk[i]);
            exp_lat = (vk[i] == 0) ? 2 : 11;
            launch(va[i], vk[i]);
            checks++; if (busy !== 1'b1) $display("FAIL vec%0d_busy got %0b exp 1", i, busy); else passed++;
            wait_done(lat);
            checks++; if (lat != exp_lat) $display("FAIL vec%0d_latency got %0d exp %0d", i, lat, exp_lat); else passed++;
            checks++; if ({error, num_out} !== exp) $display("FAIL vec%0d_result got err=%0b num=%0h exp err=%0b num=%0h", i, error, num_out, exp[4], exp[3:0]); else passed++;
            @(posedge clock); #1;
            checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL vec%0d_pulse got done=%0b busy=%0b exp 0 0", i, done, busy); else passed++;
        end
    endtask

    task automatic test_random;
        int lat;
        logic [3:0] a, k;
        logic [7:0] d;
        logic [4:0] exp;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 15));
            k = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) begin
                if (k != 0 && $urandom_range(0, 2) != 0) d = 8'($urandom_range(0, 15) * int'(k));
                else d = 8'($urandom);
                write_mem(a, d);
            end
            exp = model(mem_m[a], k);
            launch(a, k);
            wait_done(lat);
            checks++;
            if (lat != ((k == 0) ? 2 : 11) || {error, num_out} !== exp)
                $display("FAIL rand%0d d=%0h k=%0h got lat=%0d err=%0b num=%0h exp err=%0b num=%0h",
                         i, mem_m[a], k, lat, error, num_out, exp[4], exp[3:0]);
            else passed++;
        end
    endtask

    task automatic test_busy_start_and_write;
        int cyc, ndone, first, fnum, ferr;
        write_mem(4'h8, 8'h10);
        launch(4'h8, 4'h8);
        load_we = 1'b1; load_addr = 4'h8; load_data = 8'h77;
        @(posedge clock); #1;
        load_we = 1'b0;
        @(posedge clock); @(posedge clock); #1;
        load_we = 1'b1; load_data = 8'hFF;
        @(posedge clock); #1;
        load_we = 1'b0;
        start = 1'b1; rd_addr = 4'h3; key = 4'h1;
        @(posedge clock); #1;
        start = 1'b0;
        mem_m[8] = 8'hFF;
        cyc = 5; ndone = 0; first = -1; fnum = 0; ferr = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            cyc++;
            if (done) begin
                ndone++;
                if (first < 0) begin first = cyc; fnum = int'(num_out); ferr = int'(error); end
            end
        end
        checks++; if (ndone != 1) $display("FAIL busy_start_pulses got %0d exp 1", ndone); else passed++;
        checks++; if (first != 11) $display("FAIL busy_start_latency got %0d exp 11", first); else passed++;
        checks++; if (fnum != 8 || ferr != 0) $display("FAIL fetch_write_old_value got num=%0h err=%0d exp num=8 err=0", fnum, ferr); else passed++;
    endtask

    task automatic test_reset_mid;
        int lat, nd;
        write_mem(4'h8, 8'h30);
        launch(4'h8, 4'h8);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midreset_ctrl got busy=%0b done=%0b exp 0 0", busy, done); else passed++;
        checks++; if (num_out !== 4'h0 || error !== 1'b0) $display("FAIL midreset_out got num=%0h err=%0b exp 0 0", num_out, error); else passed++;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (done) nd++;
        end
        checks++; if (nd != 0) $display("FAIL midreset_no_done got %0d exp 0", nd); else passed++;
        launch(4'h8, 4'h1);
        wait_done(lat);
        checks++; if (lat != 11 || num_out !== 4'h0 || error !== 1'b0) $display("FAIL midreset_store_cleared got lat=%0d num=%0h err=%0b exp 11 0 0", lat, num_out, error); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        write_mem(4'h3, 8'h1E);
        write_mem(4'h4, 8'hC4);
        launch(4'h3, 4'hA);
        wait_done(lat);
        checks++; if (lat != 11 || num_out !== 4'b1100) $display("FAIL b2b_first got lat=%0d num=%0h exp 11 c", lat, num_out); else passed++;
        launch(4'h4, 4'hE);
        checks++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_accept got done=%0b busy=%0b exp 0 1", done, busy); else passed++;
        wait_done(lat);
        checks++; if (lat != 11 || num_out !== 4'b1011 || error !== 1'b0) $display("FAIL b2b_second got lat=%0d num=%0h err=%0b exp 11 b 0", lat, num_out, error); else passed++;
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_random;
        test_busy_start_and_write;
        test_reset_mid;
        test_back_to_back;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
